// File: rtl/down_timer.sv
// Programmable down-counting timer: load over valid/ready, prescaled decrement, one-shot or periodic.
// Optional sticky interrupt (irq/irq_clr) is built when DOWN_TIMER_IRQ_EN is defined.
`timescale 1ns/1ps

module down_timer #(
    parameter int WIDTH      = 20,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  load_periodic,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  enable,
    input  logic                  cancel,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  expire
`ifdef DOWN_TIMER_IRQ_EN
    ,
    input  logic                  irq_clr,
    output logic                  irq
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      reload_q, reload_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic                  mode_q, mode_d;
    logic                  expire_q, expire_d;
    logic                  tick;

    assign tick = enable && (presc_cnt_q == prescale_q);

    // NOTE: every register, configuration shadows included, is cleared by the async reset so the
    // block never leaves reset with unknown state; there is no memory array to exempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            mode_q      <= 1'b0;
            expire_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            mode_q      <= mode_d;
            expire_q    <= expire_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so no path through the case can infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        mode_d      = mode_q;
        expire_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    count_d     = load_value;
                    reload_d    = load_value;
                    mode_d      = load_periodic;
                    prescale_d  = prescale;
                    presc_cnt_d = '0;
                    // A zero load expires immediately and never enters the reload loop.
                    if (load_value == '0) begin
                        state_d  = ZERO;
                        expire_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end

            ZERO: begin
                state_d = IDLE;
                count_d = '0;
            end

            RUN: begin
                if (cancel) begin
                    state_d     = IDLE;
                    count_d     = '0;
                    presc_cnt_d = '0;
                end else if (tick) begin
                    presc_cnt_d = '0;
                    if (count_q == WIDTH'(1)) begin
                        expire_d = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end else if (enable) begin
                    presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign count      = count_q;
    assign expire     = expire_q;

`ifdef DOWN_TIMER_IRQ_EN
    // Sticky flag: a pending expire wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (expire_q) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: an enabled-cycle arithmetic model is compared on every negedge,
// plus literal expectations at the key points of each scenario.
`timescale 1ns/1ps

module tb_down_timer;

    localparam int WIDTH      = 20;
    localparam int PRESCALE_W = 16;

    logic                  clk           = 1'b0;
    logic                  rst_n         = 1'b0;
    logic                  load_valid    = 1'b0;
    logic [WIDTH-1:0]      load_value    = '0;
    logic                  load_periodic = 1'b0;
    logic [PRESCALE_W-1:0] prescale      = '0;
    logic                  enable        = 1'b0;
    logic                  cancel        = 1'b0;
    logic                  load_ready;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  expire;
`ifdef DOWN_TIMER_IRQ_EN
    logic                  irq_clr       = 1'b0;
    logic                  irq;
`endif

    down_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_value   (load_value),
        .load_periodic(load_periodic),
        .prescale     (prescale),
        .enable       (enable),
        .cancel       (cancel),
        .count        (count),
        .busy         (busy),
        .expire       (expire)
`ifdef DOWN_TIMER_IRQ_EN
        ,
        .irq_clr      (irq_clr),
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Model: elapsed enabled cycles since load; ticks = e/(prescale+1), remaining = N - ticks.
    bit     m_run, m_zero, m_per, m_irq;
    longint m_n, m_p, m_e;
    longint e_count;
    bit     e_busy, e_expire, e_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_zero = 0; m_per = 0; m_irq = 0;
        m_n = 0; m_p = 1; m_e = 0;
        e_count = 0; e_busy = 0; e_expire = 0; e_ready = 1;
    endtask

    task automatic model_step();
        bit old_exp;
        bit nx_exp;
        old_exp = e_expire;
        nx_exp  = 0;
        if (m_zero) begin
            m_zero  = 0;
            e_count = 0;
        end else if (!m_run) begin
            if (load_valid) begin
                if (load_value == 0) begin
                    m_zero  = 1;
                    e_count = 0;
                    nx_exp  = 1;
                end else begin
                    m_run   = 1;
                    m_n     = longint'(load_value);
                    m_p     = longint'(prescale) + 1;
                    m_per   = load_periodic;
                    m_e     = 0;
                    e_count = m_n;
                end
            end
        end else if (cancel) begin
            m_run   = 0;
            e_count = 0;
        end else if (enable) begin
            m_e++;
            if (m_e == m_n * m_p) begin
                nx_exp = 1;
                if (m_per) begin
                    m_e     = 0;
                    e_count = m_n;
                end else begin
                    m_run   = 0;
                    e_count = 0;
                end
            end else begin
                e_count = m_n - m_e / m_p;
            end
        end
        e_expire = nx_exp;
        e_busy   = m_run;
        e_ready  = !m_run && !m_zero;
`ifdef DOWN_TIMER_IRQ_EN
        if (old_exp) m_irq = 1;
        else if (irq_clr) m_irq = 0;
`else
        m_irq = old_exp;
`endif
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("count", count, e_count);
            check("busy", busy, e_busy);
            check("expire", expire, e_expire);
            check("load_ready", load_ready, e_ready);
`ifdef DOWN_TIMER_IRQ_EN
            check("irq", irq, m_irq);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic wait_expire(input int limit, output int got);
        got = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (expire === 1'b1) begin
                got = k;
                break;
            end
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] v, input logic per, input logic [PRESCALE_W-1:0] p);
        load_valid    = 1'b1;
        load_value    = v;
        load_periodic = per;
        prescale      = p;
        step();
        load_valid    = 1'b0;
    endtask

    int got;
    int per_seq[6] = '{3, 3, 2, 2, 1, 1};

    initial begin
        model_reset();
        #12;
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_expire", expire, 0);
        check("rst_ready", load_ready, 1);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        enable = 1'b1;

        // One-shot, load 5, prescale 0.
        load(20'd5, 1'b0, '0);
        check("os_load_count", count, 5);
        check("os_load_busy", busy, 1);
        check("os_load_ready", load_ready, 0);
        repeat (4) step();
        check("os_count1", count, 1);
        check("os_no_exp_yet", expire, 0);
        step();
        check("os_expire", expire, 1);
        check("os_exp_count", count, 0);
        check("os_exp_busy", busy, 0);
        check("os_exp_ready", load_ready, 1);
        step();
        check("os_exp_single", expire, 0);

        // Periodic, load 3, prescale 1: pulse every 6 cycles.
        load(20'd3, 1'b1, 16'd1);
        for (int k = 1; k <= 24; k++) begin
            step();
            check("per_count", count, per_seq[k % 6]);
            check("per_expire", expire, (k % 6) == 0);
            check("per_busy", busy, 1);
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("per_cancel_busy", busy, 0);

        // Pause for 7 cycles at count 2: expire moves 7 cycles later.
        load(20'd4, 1'b0, '0);
        repeat (2) step();
        check("pause_count2", count, 2);
        enable = 1'b0;
        repeat (7) step();
        check("pause_hold", count, 2);
        enable = 1'b1;
        wait_expire(20, got);
        check("pause_latency", got, 2);
        step();

        // Cancel on the terminal tick, then immediate reload.
        load(20'd2, 1'b0, '0);
        step();
        check("cxl_count1", count, 1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cxl_no_expire", expire, 0);
        check("cxl_count0", count, 0);
        check("cxl_ready", load_ready, 1);
        load(20'd3, 1'b0, '0);
        check("cxl_reload", count, 3);
        cancel = 1'b1;
        step();
        cancel = 1'b0;

        // Zero load with periodic set: single pulse; cancel in ZERO is ignored.
        load(20'd0, 1'b1, '0);
        check("zero_expire", expire, 1);
        check("zero_ready", load_ready, 0);
        check("zero_busy", busy, 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("zero_single", expire, 0);
        check("zero_idle", load_ready, 1);
        repeat (3) step();

        // load_valid held during a 10-count run is taken only once IDLE returns.
        load(20'd10, 1'b0, '0);
        load_valid = 1'b1;
        load_value = 20'd7;
        repeat (9) step();
        check("held_count1", count, 1);
        step();
        check("held_expire", expire, 1);
        step();
        load_valid = 1'b0;
        check("held_accept", count, 7);
        cancel = 1'b1;
        step();
        cancel = 1'b0;

        // Max load value.
        load('1, 1'b0, '0);
        check("max_load", count, 20'hFFFFF);
        step();
        check("max_dec", count, 20'hFFFFE);
        cancel = 1'b1;
        step();
        cancel = 1'b0;

        // All-ones prescale: 65536 enabled cycles per tick.
        load(20'd1, 1'b0, '1);
        wait_expire(70000, got);
        check("presc_max_latency", got, 65536);
        step();

        // Asynchronous reset in the middle of a run.
        load(20'd9, 1'b0, '0);
        step();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("arst_count", count, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", load_ready, 1);
        rst_n = 1'b1;
        step();

`ifdef DOWN_TIMER_IRQ_EN
        load(20'd1, 1'b0, '0);
        step();
        step();
        check("irq_set", irq, 1);
        load(20'd1, 1'b0, '0);
        step();
        check("irq_exp2", expire, 1);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        check("irq_set_wins", irq, 1);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        check("irq_cleared", irq, 0);
        step();
`endif

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
